alu_cmd_ctrl: RTL



---
 rtl/alu_cmd_ctrl_pkg.sv | 17 +
 rtl/alu_res_serializer.sv | 40 ++++
 rtl/alu_cmd_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_cmd_ctrl_pkg.sv
// alu_cmd_ctrl_pkg: shared state encoding, frame opcodes and ALU function codes
package alu_cmd_ctrl_pkg;
  localparam logic [7:0] CMD_ALU_OPR  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOPR = 8'hDD;
  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_EXEC, S_WAIT_RES, S_TX_LO, S_TX_HI
  } state_t;
  typedef enum logic [3:0] {
    FN_ADD   = 4'h0, FN_SUB   = 4'h1, FN_MUL   = 4'h2, FN_DIV   = 4'h3,
    FN_AND   = 4'h4, FN_OR    = 4'h5, FN_NAND  = 4'h6, FN_NOR   = 4'h7,
    FN_XOR   = 4'h8, FN_XNOR  = 4'h9, FN_CMPEQ = 4'hA, FN_CMPGT = 4'hB,
    FN_CMPLT = 4'hC, FN_SHR   = 4'hD, FN_SHL   = 4'hE
  } alu_fun_t;
  function automatic logic is_get(input state_t s);
    return s inside {S_GET_A, S_GET_B, S_GET_FUN};
  endfunction
endpackage

// File: rtl/alu_res_serializer.sv
// alu_res_serializer: holds the ALU result and sends it low byte first over valid/ready
// i_load captures i_res and presents the low byte; o_hs flags each accepted byte.
module alu_res_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_load,
  input  logic [2*DATA_WIDTH-1:0] i_res,
  input  logic                    i_tx_ready,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic                    o_tx_valid,
  output logic                    o_hs
);
  logic [2*DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_hi;
  assign o_hs       = r_valid && i_tx_ready;
  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_res   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_hi    <= 1'b0;
    end else if (i_load) begin
      r_res   <= i_res;
      r_data  <= i_res[DATA_WIDTH-1:0];
      r_valid <= 1'b1;
      r_hi    <= 1'b0;
    end else if (o_hs) begin
      // first accept switches to the high byte, second accept ends the reply
      r_data  <= r_res[2*DATA_WIDTH-1:DATA_WIDTH];
      r_hi    <= !r_hi;
      r_valid <= !r_hi;
    end
  end
endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses ALU command frames from RX bytes, drives the ALU, returns the result to TX
// Ports: CLK/RST (async active-low); rx_data/rx_valid byte stream in;
// alu_a/alu_b/alu_fun/alu_en/alu_clk_en to the ALU, alu_out/alu_valid back;
// tx_data/tx_valid/tx_ready reply handshake; busy and frame_err status.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int FRAME_TO   = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  output logic                    alu_clk_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_err
);
  localparam int CW = $clog2(FRAME_TO);
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_alu_a, r_alu_b, w_a, w_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun, w_fun;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_alu_en, r_clk_en, r_busy, r_err;
  logic                  w_err, w_load, w_hs;
  always_comb begin
    w_next = r_state;
    w_a    = r_alu_a;
    w_b    = r_alu_b;
    w_fun  = r_alu_fun;
    w_cnt  = '0;
    w_err  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: if (rx_valid) begin
        w_next = rx_data == DATA_WIDTH'(CMD_ALU_OPR)  ? S_GET_A :
                 rx_data == DATA_WIDTH'(CMD_ALU_NOPR) ? S_GET_FUN : S_IDLE;
        w_err  = w_next == S_IDLE;
      end
      S_GET_A: if (rx_valid) begin
        w_a    = rx_data;
        w_next = S_GET_B;
      end
      S_GET_B: if (rx_valid) begin
        w_b    = rx_data;
        w_next = S_GET_FUN;
      end
      S_GET_FUN: if (rx_valid) begin
        w_fun  = rx_data[FUN_WIDTH-1:0];
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WAIT_RES;
        w_err  = rx_valid;
      end
      S_WAIT_RES: begin
        // ALU latency is one cycle, so a missing result here is a fault
        w_next = alu_valid ? S_TX_LO : S_IDLE;
        w_load = alu_valid;
        w_err  = rx_valid || !alu_valid;
      end
      S_TX_LO: begin
        w_next = w_hs ? S_TX_HI : S_TX_LO;
        w_err  = rx_valid;
      end
      S_TX_HI: begin
        w_next = w_hs ? S_IDLE : S_TX_HI;
        w_err  = rx_valid;
      end
      default: w_next = S_IDLE;
    endcase
    // idle-gap timer only runs while a frame is being collected
    if (is_get(r_state) && !rx_valid) begin
      if (r_cnt == CW'(FRAME_TO - 1)) begin
        w_next = S_IDLE;
        w_err  = 1'b1;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_cnt     <= '0;
      r_alu_en  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_alu_a   <= w_a;
      r_alu_b   <= w_b;
      r_alu_fun <= w_fun;
      r_cnt     <= w_cnt;
      r_alu_en  <= w_next == S_EXEC;
      r_clk_en  <= w_next inside {S_EXEC, S_WAIT_RES};
      r_busy    <= w_next != S_IDLE;
      r_err     <= w_err;
    end
  end
  alu_res_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_load),
    .i_res     (alu_out),
    .i_tx_ready(tx_ready),
    .o_tx_data (tx_data),
    .o_tx_valid(tx_valid),
    .o_hs      (w_hs)
  );
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_fun    = r_alu_fun;
  assign alu_en     = r_alu_en;
  assign alu_clk_en = r_clk_en;
  assign busy       = r_busy;
  assign frame_err  = r_err;
endmodule
